sar_search_ctrl: RTL and testbench

- Search controller that drives the `s` operand of the team's 4-bit magnitude comparator and reads back its gt/lt/eq result each clock.
- The comparator's `f` input holds an unknown target value. This block binary-searches for that target and reports it, along with the number of probes it took.
- It is the initiator side of the comparator interface, used in the lab's guess-the-number and successive-approximation exercises.

---
 rtl/sar_search_ctrl.sv | 151 +++++++++++++++
 tb/tb_sar_search_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/sar_search_ctrl.sv
// Binary-search controller that drives the comparator `s` operand and
// narrows [low, high] from the comparator's gt/lt/eq result each cycle.
module sar_search_ctrl #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             gt,
  input  logic             lt,
  input  logic             eq,
  output logic [WIDTH-1:0] guess,
  output logic             busy,
  output logic             done,
  output logic             fail,
  output logic [WIDTH-1:0] found,
  output logic [WIDTH-1:0] steps
);

  localparam logic [WIDTH-1:0] MaxVal = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] One    = WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    HIT    = 2'd2,
    MISS   = 2'd3
  } state_t;

  state_t           state;
  state_t           stateNext;
  logic [WIDTH-1:0] low;
  logic [WIDTH-1:0] high;
  logic [WIDTH-1:0] lowNext;
  logic [WIDTH-1:0] highNext;
  logic [WIDTH-1:0] guessNext;
  logic [WIDTH-1:0] foundNext;
  logic [WIDTH-1:0] stepsNext;
  logic             busyNext;
  logic             doneNext;
  logic             failNext;

  logic             resEq;
  logic             resGt;
  logic             resLt;
  logic             atHigh;
  logic             atLow;

  // Midpoint at WIDTH+1 bits so b-a and the sum never wrap; result <= b.
  function automatic logic [WIDTH-1:0] midOf(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b);
    logic [WIDTH:0] sum;
    sum = {1'b0, a} + (({1'b0, b} - {1'b0, a}) >> 1);
    return sum[WIDTH-1:0];
  endfunction

  // Only exactly one-hot comparator results are legal.
  assign resEq  = eq & ~gt & ~lt;
  assign resGt  = gt & ~lt & ~eq;
  assign resLt  = lt & ~gt & ~eq;
  assign atHigh = (guess == high);
  assign atLow  = (guess == low);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  // Next-state selection.
  always_comb begin
    stateNext = state;
    case (state)
      SEARCH: begin
        if (resEq)                 stateNext = HIT;
        else if (resGt && !atHigh) stateNext = SEARCH;
        else if (resLt && !atLow)  stateNext = SEARCH;
        else                       stateNext = MISS;
      end
      default: begin
        if (start) stateNext = SEARCH;
      end
    endcase
  end

  // Next values of the datapath and status registers.
  always_comb begin
    lowNext   = low;
    highNext  = high;
    guessNext = guess;
    foundNext = found;
    stepsNext = steps;
    busyNext  = busy;
    doneNext  = done;
    failNext  = fail;
    case (state)
      SEARCH: begin
        stepsNext = steps + One;
        if (resEq) begin
          foundNext = guess;
          doneNext  = 1'b1;
          busyNext  = 1'b0;
        end else if (resGt && !atHigh) begin
          lowNext   = guess + One;
          guessNext = midOf(guess + One, high);
        end else if (resLt && !atLow) begin
          highNext  = guess - One;
          guessNext = midOf(low, guess - One);
        end else begin
          failNext = 1'b1;
          busyNext = 1'b0;
        end
      end
      default: begin
        if (start) begin
          lowNext   = '0;
          highNext  = MaxVal;
          guessNext = midOf('0, MaxVal);
          stepsNext = '0;
          doneNext  = 1'b0;
          failNext  = 1'b0;
          busyNext  = 1'b1;
        end
      end
    endcase
  end

  // Datapath and status registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      low   <= '0;
      high  <= '0;
      guess <= '0;
      found <= '0;
      steps <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      fail  <= 1'b0;
    end else begin
      low   <= lowNext;
      high  <= highNext;
      guess <= guessNext;
      found <= foundNext;
      steps <= stepsNext;
      busy  <= busyNext;
      done  <= doneNext;
      fail  <= failNext;
    end
  end

endmodule

// File: tb/tb_sar_search_ctrl.sv
// Directed bench for sar_search_ctrl with a behavioural comparator model.
module tb_sar_search_ctrl;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       gt;
  logic       lt;
  logic       eq;
  logic [3:0] guess;
  logic       busy;
  logic       done;
  logic       fail;
  logic [3:0] found;
  logic [3:0] steps;

  int         target;
  int         mode;     // 0 normal comparator, 1 gt tied high, 2 gt=lt=1
  int         nCmp;
  int         nBad;
  int         probes[5];

  sar_search_ctrl #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .gt    (gt),
    .lt    (lt),
    .eq    (eq),
    .guess (guess),
    .busy  (busy),
    .done  (done),
    .fail  (fail),
    .found (found),
    .steps (steps)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Comparator model: f = target, s = guess.
  always_comb begin
    gt = 1'b0;
    lt = 1'b0;
    eq = 1'b0;
    case (mode)
      1: gt = 1'b1;
      2: begin gt = 1'b1; lt = 1'b1; end
      default: begin
        gt = (target > int'(guess));
        lt = (target < int'(guess));
        eq = (target == int'(guess));
      end
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCmp++;
    assert (obs === exp) else begin
      nBad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Check each probe value while busy; leaves us on the cycle after the last sample.
  task automatic probeSeq(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s probe%0d", tag, i), 32'(guess), 32'(probes[i]));
      check($sformatf("%s busy%0d", tag, i), 32'(busy), 32'd1);
      @(negedge clk);
    end
  endtask

  // Start a search and wait for busy to fall, with a cycle budget.
  task automatic runSearch(input int tgt);
    int cyc;
    target = tgt;
    pulseStart();
    cyc = 0;
    while (busy === 1'b1 && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    check($sformatf("t%0d timeout", tgt), 32'(cyc < 10), 32'd1);
  endtask

  initial begin
    nCmp   = 0;
    nBad   = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    target = 0;
    mode   = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    check("rst guess", 32'(guess), 32'd0);
    check("rst busy",  32'(busy),  32'd0);
    check("rst done",  32'(done),  32'd0);
    check("rst fail",  32'(fail),  32'd0);
    check("rst found", 32'(found), 32'd0);
    check("rst steps", 32'(steps), 32'd0);
    @(negedge clk);
    check("idle hold busy", 32'(busy), 32'd0);

    // Target 11: 7 (gt), 11 (eq)
    target = 11;
    probes = '{7, 11, 0, 0, 0};
    pulseStart();
    probeSeq("t11", 2);
    check("t11 done",  32'(done),  32'd1);
    check("t11 fail",  32'(fail),  32'd0);
    check("t11 found", 32'(found), 32'd11);
    check("t11 steps", 32'(steps), 32'd2);
    check("t11 busy",  32'(busy),  32'd0);
    @(negedge clk);
    check("t11 hold done",  32'(done),  32'd1);
    check("t11 hold guess", 32'(guess), 32'd11);

    // Target 0: 7, 3, 1, 0
    target = 0;
    probes = '{7, 3, 1, 0, 0};
    pulseStart();
    check("t0 done cleared", 32'(done), 32'd0);
    probeSeq("t0", 4);
    check("t0 done",  32'(done),  32'd1);
    check("t0 found", 32'(found), 32'd0);
    check("t0 steps", 32'(steps), 32'd4);

    // Target 15: 7, 11, 13, 14, 15
    target = 15;
    probes = '{7, 11, 13, 14, 15};
    pulseStart();
    probeSeq("t15", 5);
    check("t15 done",  32'(done),  32'd1);
    check("t15 found", 32'(found), 32'd15);
    check("t15 steps", 32'(steps), 32'd5);

    // Sweep every target
    for (int t = 0; t < 16; t++) begin
      runSearch(t);
      check($sformatf("sweep%0d done", t),  32'(done),  32'd1);
      check($sformatf("sweep%0d fail", t),  32'(fail),  32'd0);
      check($sformatf("sweep%0d found", t), 32'(found), 32'(t));
      check($sformatf("sweep%0d steps<=5", t), 32'(steps <= 4'd5), 32'd1);
    end

    // gt tied high exhausts the range at 15
    mode = 1;
    probes = '{7, 11, 13, 14, 15};
    pulseStart();
    probeSeq("gtTied", 5);
    check("gtTied fail",  32'(fail),  32'd1);
    check("gtTied done",  32'(done),  32'd0);
    check("gtTied steps", 32'(steps), 32'd5);
    check("gtTied busy",  32'(busy),  32'd0);
    check("gtTied guess", 32'(guess), 32'd15);

    // Illegal gt=lt=1 on the first probe
    mode = 2;
    pulseStart();
    check("illegal fail cleared", 32'(fail), 32'd0);
    check("illegal probe0", 32'(guess), 32'd7);
    @(negedge clk);
    check("illegal fail",  32'(fail),  32'd1);
    check("illegal done",  32'(done),  32'd0);
    check("illegal steps", 32'(steps), 32'd1);
    check("illegal busy",  32'(busy),  32'd0);

    // Start during search is ignored; reset during the third probe aborts
    mode = 0;
    target = 0;
    pulseStart();
    check("abort probe0", 32'(guess), 32'd7);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("nostart probe1", 32'(guess), 32'd3);
    check("nostart steps",  32'(steps), 32'd1);
    @(negedge clk);
    check("abort probe2", 32'(guess), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("abort guess", 32'(guess), 32'd0);
    check("abort busy",  32'(busy),  32'd0);
    check("abort done",  32'(done),  32'd0);
    check("abort fail",  32'(fail),  32'd0);
    check("abort found", 32'(found), 32'd0);
    check("abort steps", 32'(steps), 32'd0);
    @(negedge clk);
    check("abort idle busy", 32'(busy), 32'd0);

    // Fresh search after reset: 7 (lt), 3 (gt), 5 (eq)
    runSearch(5);
    check("t5 done",  32'(done),  32'd1);
    check("t5 found", 32'(found), 32'd5);
    check("t5 steps", 32'(steps), 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
